vadd_rr_scheduler: RTL and testbench



---
 rtl/vadd_sched_pkg.sv | 26 ++
 rtl/vadd_rr_scheduler_if.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/vadd_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_vadd_rr_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vadd_sched_pkg.sv
// Shared types and defaults for the round-robin vector-add scheduler.
package vadd_sched_pkg;

   localparam int unsigned W_DEF     = 8;
   localparam int unsigned N_DEF     = 4;
   localparam int unsigned R_DEF     = 3;
   localparam int unsigned LAT_DEF   = 2;
   localparam int unsigned CNT_W     = 16;
   // Tag field is sized for up to 256 requesters; only the low tag_w(R) bits are used.
   localparam int unsigned TAG_W_MAX = 8;

   typedef logic [W_DEF-1:0] lane_t;

   typedef enum logic {INIT, RUN} state_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
   } tag_stage_t;

   // Width needed to encode a requester index.
   function automatic int unsigned tag_w(input int unsigned r);
      return (r < 2) ? 1 : $clog2(r);
   endfunction

endpackage

// File: rtl/vadd_rr_scheduler_if.sv
// Requester-side bus: operand handshake, result return and issue counters.
interface vadd_rr_scheduler_if
   import vadd_sched_pkg::*;
#(
   parameter int unsigned W = W_DEF,
   parameter int unsigned N = N_DEF,
   parameter int unsigned R = R_DEF
);
   logic [R-1:0]       req_valid;
   logic [R-1:0]       req_ready;
   logic [R*N*W-1:0]   req_a;
   logic [R*N*W-1:0]   req_b;
   logic [R-1:0]       rsp_valid;
   logic [N*W-1:0]     rsp_y;
   logic [R*CNT_W-1:0] issue_count;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_y, issue_count
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_y, issue_count
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping modulo R.
module rr_arbiter #(
   parameter int unsigned R  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [R-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [R-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Scan R positions starting at ptr; the first asserted request wins.
   always_comb begin
      int unsigned j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < R; k++) begin
         j = 32'(ptr) + k;
         if (j >= R) j = j - R;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end
endmodule

// File: rtl/vadd_rr_scheduler.sv
// Shares one registered N-lane vector adder among R requesters, round-robin.
module vadd_rr_scheduler
   import vadd_sched_pkg::*;
#(
   parameter int unsigned W   = W_DEF,
   parameter int unsigned N   = N_DEF,
   parameter int unsigned R   = R_DEF,
   parameter int unsigned LAT = LAT_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   vadd_rr_scheduler_if.slave    bus,
   output logic                  dp_reset,
   output logic [N*W-1:0]        dp_a,
   output logic [N*W-1:0]        dp_b,
   input  logic [N*W-1:0]        dp_y
);
   localparam int unsigned VW = N * W;
   localparam int unsigned TW = tag_w(R);

   logic [1:0]       rst_sync_q;
   state_t           state_q, state_d;
   logic [TW-1:0]    ptr_q, ptr_d;
   logic [R-1:0]     grant;
   logic [TW-1:0]    grant_idx;
   logic             grant_any;
   logic [R-1:0]     ready;
   logic             xfer;
   logic [CNT_W-1:0] cnt_q [R];
   tag_stage_t       pipe_q [LAT];
   logic [R-1:0]     rsp_valid_d, rsp_valid_q;
   logic [VW-1:0]    rsp_y_q;

   // Datapath reset: asserts with reset_n, releases on the second clock edge after.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b11;
      else          rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign dp_reset = rst_sync_q[1];

   rr_arbiter #(.R(R), .IW(TW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Next state, grant and operand steering; operands are zero on idle cycles.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ready   = '0;
      xfer    = 1'b0;
      dp_a    = '0;
      dp_b    = '0;
      case (state_q)
         INIT: if (!dp_reset) state_d = RUN;
         RUN: begin
            if (grant_any) begin
               ready = grant;
               xfer  = 1'b1;
               dp_a  = bus.req_a[32'(grant_idx)*VW +: VW];
               dp_b  = bus.req_b[32'(grant_idx)*VW +: VW];
               ptr_d = (grant_idx == TW'(R-1)) ? '0 : grant_idx + TW'(1);
            end
         end
         default: state_d = INIT;
      endcase
   end

   // State and round-robin pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Per-requester accepted-operation counters, free-running wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < R; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < R; i++)
            if (xfer && grant[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
   end

   // Tag pipe mirrors the datapath latency so each result finds its owner.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
      end else begin
         pipe_q[0] <= '{valid: xfer, tag: TAG_W_MAX'(grant_idx)};
         for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   // Decode the last tag stage into a one-hot response strobe.
   always_comb begin
      rsp_valid_d = '0;
      for (int i = 0; i < R; i++)
         rsp_valid_d[i] = pipe_q[LAT-1].valid && (pipe_q[LAT-1].tag == TAG_W_MAX'(i));
   end

   // Register the response; the result holds between responses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= '0;
         rsp_y_q     <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (pipe_q[LAT-1].valid) rsp_y_q <= dp_y;
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = rsp_y_q;

   for (genvar g = 0; g < R; g++) begin : g_cnt
      assign bus.issue_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_vadd_rr_scheduler.sv
// Directed bench for vadd_rr_scheduler with a behavioural two-stage adder.
module tb_vadd_rr_scheduler;
   import vadd_sched_pkg::*;

   localparam int unsigned W   = 8;
   localparam int unsigned N   = 4;
   localparam int unsigned R   = 3;
   localparam int unsigned LAT = 2;
   localparam int unsigned VW  = N * W;
   localparam int unsigned AW  = R * VW;
   localparam int unsigned NV  = 23;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b1;
   logic          dp_reset;
   logic [VW-1:0] dp_a, dp_b, dp_y;
   logic [VW-1:0] in_a_q, in_b_q;
   int            checks   = 0;
   int            failures = 0;
   int            bad      = 0;

   vadd_rr_scheduler_if #(.W(W), .N(N), .R(R)) bus ();

   vadd_rr_scheduler #(.W(W), .N(N), .R(R), .LAT(LAT)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus),
      .dp_reset (dp_reset),
      .dp_a     (dp_a),
      .dp_b     (dp_b),
      .dp_y     (dp_y)
   );

   always #5 clock = ~clock;

   // Datapath: input register, lane-wise add into output register, sync reset.
   always_ff @(posedge clock) begin
      if (dp_reset) begin
         in_a_q <= '0;
         in_b_q <= '0;
         dp_y   <= '0;
      end else begin
         in_a_q <= dp_a;
         in_b_q <= dp_b;
         for (int j = 0; j < N; j++)
            dp_y[j*W +: W] <= lane_t'(in_a_q[j*W +: W] + in_b_q[j*W +: W]);
      end
   end

   typedef struct {
      logic [R-1:0]  valid;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [R-1:0]  exp_ready;
      logic [R-1:0]  exp_rsp;
      logic [VW-1:0] exp_y;
   } vec_t;

   vec_t vecs [NV];

   localparam logic [AW-1:0] FA = {32'h03030303, 32'h02020202, 32'h01010101};
   localparam logic [AW-1:0] FB = {32'h30303030, 32'h20202020, 32'h10101010};

   function automatic logic [AW-1:0] slot(input int unsigned i, input logic [VW-1:0] v);
      logic [AW-1:0] r;
      r = '0;
      r[i*VW +: VW] = v;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int t, input logic [R-1:0] v, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [R-1:0] er,
                          input logic [R-1:0] rs, input logic [VW-1:0] y);
      vecs[t] = '{v, a, b, er, rs, y};
   endtask

   task automatic drive(input logic [R-1:0] v, input logic [AW-1:0] a, input logic [AW-1:0] b);
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
   endtask

   // Assert reset for 3 cycles, release, and follow dp_reset through INIT.
   task automatic apply_reset();
      reset_n = 1'b0;
      drive('0, '0, '0);
      repeat (3) begin @(posedge clock); #1; end
      check("rst_ready",     64'(bus.req_ready),   64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid),   64'(0));
      check("rst_rsp_y",     64'(bus.rsp_y),       64'(0));
      check("rst_dp_a",      64'(dp_a),            64'(0));
      check("rst_dp_b",      64'(dp_b),            64'(0));
      check("rst_count",     64'(bus.issue_count), 64'(0));
      check("rst_dp_reset",  64'(dp_reset),        64'(1));
      reset_n = 1'b1;
      drive(3'b111, FA, FB);
      @(posedge clock); #1;
      check("rel_edge1_dp_reset", 64'(dp_reset),      64'(1));
      check("rel_edge1_ready",    64'(bus.req_ready), 64'(0));
      check("rel_edge1_rsp",      64'(bus.rsp_valid), 64'(0));
      @(posedge clock); #1;
      check("rel_edge2_dp_reset", 64'(dp_reset),      64'(0));
      check("rel_edge2_ready",    64'(bus.req_ready), 64'(0));
      check("rel_edge2_rsp",      64'(bus.rsp_valid), 64'(0));
      drive('0, '0, '0);
   endtask

   initial begin
      #400_0000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Fairness: all valid, grants rotate 0,1,2; results land three drive-cycles later.
      set_vec( 0, 3'b111, FA, FB, 3'b001, 3'b000, 32'h00000000);
      set_vec( 1, 3'b111, FA, FB, 3'b010, 3'b000, 32'h00000000);
      set_vec( 2, 3'b111, FA, FB, 3'b100, 3'b000, 32'h00000000);
      set_vec( 3, 3'b111, FA, FB, 3'b001, 3'b001, 32'h11111111);
      set_vec( 4, 3'b111, FA, FB, 3'b010, 3'b010, 32'h22222222);
      set_vec( 5, 3'b111, FA, FB, 3'b100, 3'b100, 32'h33333333);
      set_vec( 6, 3'b111, FA, FB, 3'b001, 3'b001, 32'h11111111);
      set_vec( 7, 3'b111, FA, FB, 3'b010, 3'b010, 32'h22222222);
      set_vec( 8, 3'b111, FA, FB, 3'b100, 3'b100, 32'h33333333);
      // Single op {1,2,3,4}+{10,20,30,40}, then lane wrap FF+02.
      set_vec( 9, 3'b010, slot(1, 32'h04030201), slot(1, 32'h281E140A), 3'b010, 3'b001, 32'h11111111);
      set_vec(10, 3'b100, slot(2, 32'hFFFFFFFF), slot(2, 32'h02020202), 3'b100, 3'b010, 32'h22222222);
      set_vec(11, 3'b000, '0, '0, 3'b000, 3'b100, 32'h33333333);
      set_vec(12, 3'b000, '0, '0, 3'b000, 3'b010, 32'h2C21160B);
      set_vec(13, 3'b000, '0, '0, 3'b000, 3'b100, 32'h01010101);
      set_vec(14, 3'b000, '0, '0, 3'b000, 3'b000, 32'h01010101);
      // Gaps: requester 2 twice, idle, requester 0 once.
      set_vec(15, 3'b100, slot(2, 32'h0A0A0A0A), slot(2, 32'h01020304), 3'b100, 3'b000, 32'h01010101);
      set_vec(16, 3'b100, slot(2, 32'h80808080), slot(2, 32'h80808080), 3'b100, 3'b000, 32'h01010101);
      set_vec(17, 3'b000, '0, '0, 3'b000, 3'b000, 32'h01010101);
      set_vec(18, 3'b001, slot(0, 32'h12345678), slot(0, 32'h11111111), 3'b001, 3'b100, 32'h0B0C0D0E);
      set_vec(19, 3'b000, '0, '0, 3'b000, 3'b100, 32'h00000000);
      set_vec(20, 3'b000, '0, '0, 3'b000, 3'b000, 32'h00000000);
      set_vec(21, 3'b000, '0, '0, 3'b000, 3'b001, 32'h23456789);
      set_vec(22, 3'b000, '0, '0, 3'b000, 3'b000, 32'h23456789);

      drive('0, '0, '0);
      #2;
      apply_reset();

      for (int t = 0; t < NV; t++) begin
         @(posedge clock); #1;
         drive(vecs[t].valid, vecs[t].a, vecs[t].b);
         #1;
         check($sformatf("v%0d_ready", t),     64'(bus.req_ready), 64'(vecs[t].exp_ready));
         check($sformatf("v%0d_rsp_valid", t), 64'(bus.rsp_valid), 64'(vecs[t].exp_rsp));
         check($sformatf("v%0d_rsp_y", t),     64'(bus.rsp_y),     64'(vecs[t].exp_y));
         if (t == 9)
            check("count_fair", 64'(bus.issue_count), 64'({16'd3, 16'd3, 16'd3}));
      end
      check("count_after_table", 64'(bus.issue_count), 64'({16'd6, 16'd4, 16'd4}));

      // Mid-flight reset: two ops issued, reset one cycle later, nothing returns.
      @(posedge clock); #1;
      drive(3'b010, slot(1, 32'h55555555), slot(1, 32'h11111111));
      #1 check("mf_ready_1", 64'(bus.req_ready), 64'(3'b010));
      @(posedge clock); #1;
      drive(3'b100, slot(2, 32'h66666666), slot(2, 32'h11111111));
      #1 check("mf_ready_2", 64'(bus.req_ready), 64'(3'b100));
      @(posedge clock); #1;
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         check($sformatf("mf_drop_%0d", c), 64'(bus.rsp_valid), 64'(0));
      end

      // Normal operation after re-init.
      @(posedge clock); #1;
      drive(3'b001, slot(0, 32'h01010101), slot(0, 32'h01010101));
      #1 check("post_ready", 64'(bus.req_ready), 64'(3'b001));
      @(posedge clock); #1;
      drive('0, '0, '0);
      check("post_rsp_gap1", 64'(bus.rsp_valid), 64'(0));
      @(posedge clock); #1;
      check("post_rsp_gap2", 64'(bus.rsp_valid), 64'(0));
      @(posedge clock); #1;
      check("post_rsp_valid", 64'(bus.rsp_valid),   64'(3'b001));
      check("post_rsp_y",     64'(bus.rsp_y),       64'(32'h02020202));
      check("post_count",     64'(bus.issue_count), 64'({16'd0, 16'd0, 16'd1}));

      // Single requester granted every cycle; its counter wraps at 2^16.
      @(posedge clock); #1;
      drive(3'b010, '0, '0);
      bad = 0;
      repeat (65535) begin
         @(posedge clock); #1;
         if (bus.req_ready !== 3'b010) bad++;
      end
      check("single_req_every_cycle", 64'(bad), 64'(0));
      check("count_ffff", 64'(bus.issue_count), 64'({16'd0, 16'hFFFF, 16'd1}));
      @(posedge clock); #1;
      check("count_wrap", 64'(bus.issue_count), 64'({16'd0, 16'd0, 16'd1}));
      drive('0, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
